// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. One full-adder cell and a registered carry are reused
// over WIDTH clock cycles. Each cycle adds one bit pair, starting at the LSB.
// The result is {cout, s} = a + b + cin, exact over WIDTH+1 bits.
//
// Operation
//   - A start strobe seen while idle captures a, b and cin. It also clears
//     the bit counter and raises busy.
//   - Each RUN cycle feeds a_sh[0], b_sh[0] and the carry register into the
//     cell. The sum bit enters the partial-sum register at its MSB.
//   - The WIDTH-th RUN edge loads s and cout, pulses done for one cycle and
//     drops busy. A start seen in that done cycle is accepted at once.
//   - start is ignored while busy is high.
//
// Parameters
//   WIDTH  operand and sum width in bits. Legal range is 1 to 32.
//
// Ports
//   clk    in   1      system clock, rising edge
//   rst    in   1      synchronous, active-high reset; aborts any addition
//   start  in   1      request strobe, sampled only while busy=0
//   a      in   WIDTH  operand A, captured on the accepting edge
//   b      in   WIDTH  operand B, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   s      out  WIDTH  sum of the last completed operation (registered)
//   cout   out  1      carry-out of the last completed operation (registered)
//   busy   out  1      high while an addition is in progress
//   done   out  1      one-cycle pulse when s and cout update
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// serial_adder_fa
//
// One-bit full-adder cell. The serial adder uses exactly one of these.
//
// Ports
//   i_x, i_y  in   1  operand bits
//   i_c       in   1  carry in
//   o_s       out  1  sum bit
//   o_c       out  1  carry out
// -----------------------------------------------------------------------------
module serial_adder_fa (
    input  logic i_x,
    input  logic i_y,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_p;  // propagate

    assign w_p = i_x ^ i_y;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_x & i_y) | (i_c & w_p);

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    // The counter must be at least one bit wide, even when WIDTH=1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    // The partial-sum register holds the bits finished before the final
    // cycle. The final bit goes straight from the cell into s, so WIDTH-1
    // bits are enough. It is kept at one bit minimum so that the
    // declaration stays legal.
    localparam int PW = (WIDTH > 1) ? WIDTH - 1 : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_carry;
    logic [PW-1:0]      r_psum;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_s;
    logic               r_cout;
    logic               r_busy;
    logic               r_done;

    logic               w_sum;
    logic               w_carry;
    logic [PW-1:0]      w_psum_shift;  // partial sum after this cycle's shift
    logic [WIDTH-1:0]   w_sum_full;    // complete sum, including this cycle's bit

    serial_adder_fa u_fa (
        .i_x (r_a_sh[0]),
        .i_y (r_b_sh[0]),
        .i_c (r_carry),
        .o_s (w_sum),
        .o_c (w_carry)
    );

    // Bits are produced LSB first and enter the register at its MSB. After
    // WIDTH-1 right shifts, the first bit has reached bit 0. Concatenating
    // the current bit above the partial sum gives the finished word.
    if (WIDTH == 1) begin : g_w1
        assign w_psum_shift = 1'b0;
        assign w_sum_full   = w_sum;
    end else if (WIDTH == 2) begin : g_w2
        assign w_psum_shift = w_sum;
        assign w_sum_full   = {w_sum, r_psum};
    end else begin : g_wn
        assign w_psum_shift = {w_sum, r_psum[PW-1:1]};
        assign w_sum_full   = {w_sum, r_psum};
    end

    // NOTE: every register here is assigned with non-blocking (<=). All of
    // them then update together from the values seen before the edge. With
    // blocking (=) assignments, the result would depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_psum  <= '0;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            // done is a one-cycle pulse. It is raised again below only
            // on the final RUN edge.
            r_done <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_psum  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_carry <= w_carry;
                    r_psum  <= w_psum_shift;
                    r_cnt   <= r_cnt + CNT_W'(1);

                    if (r_cnt == LAST_BIT) begin
                        r_s     <= w_sum_full;
                        r_cout  <= w_carry;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Bench for serial_adder with two instances: WIDTH=8 and WIDTH=1. Both
// instances share clk, rst, start and cin. The WIDTH=1 instance sees only
// bit 0 of a and b.
//
// A reference model tracks each instance from arithmetic and a cycle
// countdown. A negedge process compares every output of both instances
// against the model on every cycle. Directed sequences add hand-computed
// literal expectations.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;

    logic [7:0] s8;
    logic       cout8;
    logic       busy8;
    logic       done8;

    logic [0:0] s1;
    logic       cout1;
    logic       busy1;
    logic       done1;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s8),
        .cout  (cout8),
        .busy  (busy8),
        .done  (done8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a[0]),
        .b     (b[0]),
        .cin   (cin),
        .s     (s1),
        .cout  (cout1),
        .busy  (busy1),
        .done  (done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model. Index 0 is the WIDTH=8 instance and index 1 is
    // WIDTH=1. An accepted start loads a countdown of WIDTH RUN cycles and
    // the exact sum a+b+cin. The result appears when the countdown expires.
    // ---------------------------------------------------------------------
    int          m_w [2] = '{8, 1};
    logic        m_busy [2];
    logic        m_done [2];
    int          m_left [2];
    logic [32:0] m_res [2];
    logic [31:0] m_s [2];
    logic        m_cout [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_busy[i] <= 1'b0;
                m_done[i] <= 1'b0;
                m_left[i] <= 0;
                m_res[i]  <= '0;
                m_s[i]    <= '0;
                m_cout[i] <= 1'b0;
            end else begin
                m_done[i] <= 1'b0;
                if (!m_busy[i]) begin
                    if (start) begin
                        m_busy[i] <= 1'b1;
                        m_left[i] <= m_w[i];
                        if (i == 0)
                            m_res[i] <= 33'(a) + 33'(b) + 33'(cin);
                        else
                            m_res[i] <= 33'(a[0]) + 33'(b[0]) + 33'(cin);
                    end
                end else if (m_left[i] == 1) begin
                    m_busy[i] <= 1'b0;
                    m_done[i] <= 1'b1;
                    m_s[i]    <= m_res[i][31:0] & ((32'd1 << m_w[i]) - 32'd1);
                    m_cout[i] <= m_res[i][m_w[i]];
                end else begin
                    m_left[i] <= m_left[i] - 1;
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc8_s",    32'(s8),    m_s[0]);
            check("cyc8_cout", 32'(cout8), 32'(m_cout[0]));
            check("cyc8_busy", 32'(busy8), 32'(m_busy[0]));
            check("cyc8_done", 32'(done8), 32'(m_done[0]));
            check("cyc1_s",    32'(s1),    m_s[1]);
            check("cyc1_cout", 32'(cout1), 32'(m_cout[1]));
            check("cyc1_busy", 32'(busy1), 32'(m_busy[1]));
            check("cyc1_done", 32'(done1), 32'(m_done[1]));
        end
    end

    // Runs one WIDTH=8 addition to completion. Checks the busy length and
    // the literal result, then checks that done lasts exactly one cycle.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [7:0] exp_s,
                        input logic exp_c, input string name);
        int busy_cnt;
        bit seen;
        busy_cnt = 0;
        seen = 1'b0;
        start = 1'b1; a = ta; b = tb; cin = tc;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (done8) begin
                seen = 1'b1;
                break;
            end
            if (busy8) busy_cnt++;
            @(negedge clk);
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
        check({name, "_busy_len"}, busy_cnt, 8);
        check({name, "_s"}, 32'(s8), 32'(exp_s));
        check({name, "_cout"}, 32'(cout8), 32'(exp_c));
        @(negedge clk);
        check({name, "_done_fall"}, 32'(done8), 32'd0);
    endtask

    logic [1:0] w1_tbl [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        int pulses;
        int first_k;
        int last_k;
        logic [7:0] s_at_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_s",    32'(s8),    32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero operands, then carry boundaries and a mixed pattern.
        run8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "zero");
        run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap");
        run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "max");
        run8(8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0, "mixed");
        repeat (2) @(negedge clk);

        // WIDTH=1: every {a,b,cin} combination, issued back-to-back.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vv;
            vv = 3'(v);
            start = 1'b1; a = {7'b0, vv[2]}; b = {7'b0, vv[1]}; cin = vv[0];
            @(negedge clk);
            start = 1'b0;
            check("w1_busy", 32'(busy1), 32'd1);
            @(negedge clk);
            check("w1_done", 32'(done1), 32'd1);
            check("w1_sum", 32'({cout1, s1}), 32'(w1_tbl[v]));
        end
        repeat (12) @(negedge clk);

        // A start during busy is ignored.
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        s_at_done = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) begin
                pulses++;
                s_at_done = s8;
            end
        end
        check("ign_pulses", pulses, 1);
        check("ign_s", 32'(s_at_done), 32'h30);
        check("ign_cout", 32'(cout8), 32'd0);

        // Reset in the 4th busy cycle aborts the addition.
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_s",    32'(s8),    32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run8(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, "after_abort");
        repeat (2) @(negedge clk);

        // start held high: a new result every 9 cycles. busy is low only
        // in the done cycles.
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
        pulses = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 27; k++) begin
            @(negedge clk);
            check("b2b_busy", 32'(busy8), 32'(!done8));
            if (done8) begin
                pulses++;
                if (first_k < 0) first_k = k;
                last_k = k;
                check("b2b_s", 32'(s8), 32'h02);
            end
        end
        start = 1'b0;
        check("b2b_pulses", pulses, 3);
        check("b2b_first", first_k, 8);
        check("b2b_span", last_k - first_k, 18);
        repeat (12) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
